// File: rtl/key_expansion_ctrl.sv
// AES-128 key-schedule controller: expands a cipher key into round keys 0..10,
// one word per cycle through a single shared sub_word, with a valid/ready output.
// Optional round-key store enabled by defining KEY_STORE_EN.

module key_expansion_ctrl_sub_word (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

module key_expansion_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  output logic [127:0] o_rk,
  output logic [3:0]   o_rk_round,
  output logic         o_rk_valid,
  input  logic         i_rk_ready,
`ifdef KEY_STORE_EN
  input  logic [3:0]   i_rd_round,
  output logic [127:0] o_rd_key,
`endif
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {IDLE, PRESENT, EXPAND, FINISH} state_t;

  state_t        state, state_next;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   w0_next, w1_next, w2_next, w3_next;
  logic [1:0]    j, j_next;
  logic [7:0]    rcon, rcon_next;
  logic [127:0]  rk_next;
  logic [3:0]    rk_round_next;
  logic          rk_valid_next, busy_next, done_next;
  logic          handshake;
  logic [31:0]   sub_in, sub_out;

  key_expansion_ctrl_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  assign handshake = o_rk_valid & i_rk_ready;

  always_comb begin
    state_next    = state;
    w0_next       = w0;
    w1_next       = w1;
    w2_next       = w2;
    w3_next       = w3;
    j_next        = j;
    rcon_next     = rcon;
    rk_next       = o_rk;
    rk_round_next = o_rk_round;
    rk_valid_next = o_rk_valid;
    busy_next     = o_busy;
    done_next     = o_done;
    // sub_word only sees RotWord(w3) on the step that consumes it
    sub_in        = (state == EXPAND && j == 2'd0) ? {w3[23:0], w3[31:24]} : '0;

    case (state)
      IDLE: begin
        if (i_start) begin
          w0_next       = i_key[127:96];
          w1_next       = i_key[95:64];
          w2_next       = i_key[63:32];
          w3_next       = i_key[31:0];
          rk_next       = i_key;
          rk_round_next = '0;
          rk_valid_next = 1'b1;
          busy_next     = 1'b1;
          state_next    = PRESENT;
        end
      end

      PRESENT: begin
        if (handshake) begin
          rk_valid_next = 1'b0;
          if (o_rk_round == 4'(NUM_ROUNDS)) begin
            done_next  = 1'b1;
            state_next = FINISH;
          end else begin
            j_next     = '0;
            state_next = EXPAND;
          end
        end
      end

      EXPAND: begin
        j_next = j + 2'd1;
        case (j)
          2'd0: w0_next = w0 ^ sub_out ^ {rcon, 24'h0};
          2'd1: w1_next = w1 ^ w0;
          2'd2: w2_next = w2 ^ w1;
          default: begin
            // w3' is not registered yet, so the round key takes it combinationally
            w3_next       = w3 ^ w2;
            rk_next       = {w0, w1, w2, w3 ^ w2};
            rk_round_next = o_rk_round + 4'd1;
            rk_valid_next = 1'b1;
            rcon_next     = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            state_next    = PRESENT;
          end
        endcase
      end

      FINISH: begin
        done_next  = 1'b0;
        busy_next  = 1'b0;
        rcon_next  = 8'h01;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      w0         <= '0;
      w1         <= '0;
      w2         <= '0;
      w3         <= '0;
      j          <= '0;
      rcon       <= 8'h01;
      o_rk       <= '0;
      o_rk_round <= '0;
      o_rk_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_next;
      w0         <= w0_next;
      w1         <= w1_next;
      w2         <= w2_next;
      w3         <= w3_next;
      j          <= j_next;
      rcon       <= rcon_next;
      o_rk       <= rk_next;
      o_rk_round <= rk_round_next;
      o_rk_valid <= rk_valid_next;
      o_busy     <= busy_next;
      o_done     <= done_next;
    end
  end

`ifdef KEY_STORE_EN
  logic [127:0] store [0:NUM_ROUNDS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
        store[i] <= '0;
      end
      o_rd_key <= '0;
    end else begin
      if (handshake) begin
        store[o_rk_round] <= o_rk;
      end
      if (i_rd_round <= 4'(NUM_ROUNDS)) begin
        o_rd_key <= store[i_rd_round];
      end else begin
        o_rd_key <= '0;
      end
    end
  end
`endif

endmodule
